// File: rtl/dram_gate_pkg.sv
// Shared types for the DRAM traffic gate: FSM states, state_o codes and
// the default AXI request/response structs used at the gate boundary.
package dram_gate_pkg;

  typedef enum logic [2:0] {
    WAIT_CALIB = 3'd0,
    RUN        = 3'd1,
    DRAIN      = 3'd2,
    SR_ENTER   = 3'd3,
    SR_HOLD    = 3'd4,
    SR_EXIT    = 3'd5
  } dram_gate_state_e;

  // Externally visible state codes; the three self-refresh phases share one code.
  localparam logic [1:0] ENC_WAIT_CALIB = 2'd0;
  localparam logic [1:0] ENC_RUN        = 2'd1;
  localparam logic [1:0] ENC_DRAIN      = 2'd2;
  localparam logic [1:0] ENC_SR         = 2'd3;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } dram_axi_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } dram_axi_w_t;

  typedef struct packed {
    logic [3:0] id;
  } dram_axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic        last;
  } dram_axi_r_t;

  typedef struct packed {
    dram_axi_ax_t aw;
    logic         aw_valid;
    dram_axi_w_t  w;
    logic         w_valid;
    logic         b_ready;
    dram_axi_ax_t ar;
    logic         ar_valid;
    logic         r_ready;
  } dram_axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    dram_axi_b_t b;
    logic        b_valid;
    dram_axi_r_t r;
    logic        r_valid;
  } dram_axi_rsp_t;

endpackage

// File: rtl/dram_gate_txn_cnt.sv
// Saturation-checked up/down transaction counter with full/empty flags.
// Coincident inc and dec cancel; wrapping is treated as an upstream bug.
module dram_gate_txn_cnt #(
  parameter int unsigned Max = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam int unsigned CntW = $clog2(Max + 1);
  localparam logic [CntW-1:0] MaxVal = CntW'(Max);

  logic [CntW-1:0] cnt_reg;

  // Count accepted requests up and retired ones down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (inc && !dec) begin
      cnt_reg <= cnt_reg + 1'b1;
    end else if (dec && !inc) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign full  = (cnt_reg == MaxVal);
  assign empty = (cnt_reg == '0);

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(inc && !dec && full));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n) !(dec && !inc && empty));

endmodule

// File: rtl/dram_traffic_gate.sv
// Gates AXI traffic into the DRAM controller: blocks AW/AR until calibration,
// bounds outstanding reads/writes, and drains traffic before self-refresh.
module dram_traffic_gate
  import dram_gate_pkg::*;
#(
  parameter int unsigned MaxTxns      = 8,
  parameter int unsigned CalibTimeout = 2**20,
  parameter int unsigned SyncStages   = 3,
  parameter type         axi_req_t    = dram_gate_pkg::dram_axi_req_t,
  parameter type         axi_rsp_t    = dram_gate_pkg::dram_axi_rsp_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  axi_req_t   slv_req_i,
  output axi_rsp_t   slv_rsp_o,
  output axi_req_t   mst_req_o,
  input  axi_rsp_t   mst_rsp_i,
  input  logic       calib_done_i,
  input  logic       sr_req_i,
  output logic       app_sr_req_o,
  input  logic       sr_active_i,
  output logic [1:0] state_o,
  output logic       calib_timeout_o
);

  localparam int unsigned TmoW = (CalibTimeout > 0) ? $clog2(CalibTimeout + 1) : 1;
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(CalibTimeout);
  localparam logic [TmoW-1:0] TmoLast = TmoW'((CalibTimeout > 0) ? CalibTimeout - 1 : 0);

  dram_gate_state_e state_reg;
  logic [1:0]       state_code_reg;
  logic             app_sr_req_reg;

  logic [SyncStages-1:0] calib_sync_reg, calib_sync_d;
  logic [SyncStages-1:0] sra_sync_reg, sra_sync_d;
  logic                  calib_sync, sra_sync;

  logic            ar_hold_reg, aw_hold_reg;
  logic            ar_open, aw_open, w_open;
  logic            ar_hs, aw_hs, w_last_hs, r_last_hs, b_hs;
  logic            rd_full, rd_empty, wr_full, wr_empty, w_owed_full, w_owed_empty;
  logic [TmoW-1:0] tmo_cnt_reg;
  logic            calib_timeout_reg;

  // Synchronizer chains: stage 0 samples the async input, later stages shift.
  for (genvar gi = 0; gi < SyncStages; gi++) begin : g_sync
    if (gi == 0) begin : g_head
      assign calib_sync_d[gi] = calib_done_i;
      assign sra_sync_d[gi]   = sr_active_i;
    end else begin : g_tail
      assign calib_sync_d[gi] = calib_sync_reg[gi-1];
      assign sra_sync_d[gi]   = sra_sync_reg[gi-1];
    end
  end

  // Advance both synchronizer chains.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      calib_sync_reg <= '0;
      sra_sync_reg   <= '0;
    end else begin
      calib_sync_reg <= calib_sync_d;
      sra_sync_reg   <= sra_sync_d;
    end
  end

  assign calib_sync = calib_sync_reg[SyncStages-1];
  assign sra_sync   = sra_sync_reg[SyncStages-1];

  // A request already presented downstream stays open until it handshakes,
  // regardless of later state or counter changes.
  assign ar_open = ((state_reg == RUN) && !rd_full) || ar_hold_reg;
  assign aw_open = ((state_reg == RUN) && !wr_full) || aw_hold_reg;

  assign ar_hs = slv_req_i.ar_valid && mst_rsp_i.ar_ready && ar_open;
  assign aw_hs = slv_req_i.aw_valid && mst_rsp_i.aw_ready && aw_open;

  // W data may only follow an address that is accepted now or earlier.
  assign w_open    = !w_owed_empty || aw_hs;
  assign w_last_hs = slv_req_i.w_valid && mst_rsp_i.w_ready && w_open && slv_req_i.w.last;
  assign r_last_hs = mst_rsp_i.r_valid && slv_req_i.r_ready && mst_rsp_i.r.last;
  assign b_hs      = mst_rsp_i.b_valid && slv_req_i.b_ready;

  // Pass everything through, overriding only the gated valid/ready pairs.
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = slv_req_i.ar_valid && ar_open;
    mst_req_o.aw_valid = slv_req_i.aw_valid && aw_open;
    mst_req_o.w_valid  = slv_req_i.w_valid && w_open;
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready && ar_open;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready && aw_open;
    slv_rsp_o.w_ready  = mst_rsp_i.w_ready && w_open;
  end

  // Remember address requests that were offered downstream but not yet taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_hold_reg <= 1'b0;
      aw_hold_reg <= 1'b0;
    end else begin
      ar_hold_reg <= mst_req_o.ar_valid && !mst_rsp_i.ar_ready;
      aw_hold_reg <= mst_req_o.aw_valid && !mst_rsp_i.aw_ready;
    end
  end

  dram_gate_txn_cnt #(.Max(MaxTxns)) u_rd_cnt (
    .clk(clk_i), .rst_n(rst_ni), .inc(ar_hs), .dec(r_last_hs), .full(rd_full), .empty(rd_empty)
  );

  dram_gate_txn_cnt #(.Max(MaxTxns)) u_wr_cnt (
    .clk(clk_i), .rst_n(rst_ni), .inc(aw_hs), .dec(b_hs), .full(wr_full), .empty(wr_empty)
  );

  dram_gate_txn_cnt #(.Max(MaxTxns)) u_w_owed (
    .clk(clk_i), .rst_n(rst_ni), .inc(aw_hs), .dec(w_last_hs), .full(w_owed_full), .empty(w_owed_empty)
  );

  // Calibration watchdog: counts only while waiting, flag is sticky until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_reg       <= '0;
      calib_timeout_reg <= 1'b0;
    end else if (state_reg == WAIT_CALIB) begin
      if (tmo_cnt_reg != TmoMax) begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
      if ((CalibTimeout != 0) && (tmo_cnt_reg == TmoLast)) begin
        calib_timeout_reg <= 1'b1;
      end
    end else begin
      tmo_cnt_reg <= '0;
    end
  end

  // Main sequencer: calibration, run, drain and the app_sr handshake.
  // Drain completes only when no address request is still parked downstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= WAIT_CALIB;
      state_code_reg <= ENC_WAIT_CALIB;
      app_sr_req_reg <= 1'b0;
    end else begin
      case (state_reg)
        WAIT_CALIB: begin
          if (calib_sync) begin
            state_reg      <= RUN;
            state_code_reg <= ENC_RUN;
          end
        end
        RUN: begin
          if (!calib_sync) begin
            state_reg      <= WAIT_CALIB;
            state_code_reg <= ENC_WAIT_CALIB;
          end else if (sr_req_i) begin
            state_reg      <= DRAIN;
            state_code_reg <= ENC_DRAIN;
          end
        end
        DRAIN: begin
          if (!calib_sync) begin
            state_reg      <= WAIT_CALIB;
            state_code_reg <= ENC_WAIT_CALIB;
          end else if (!sr_req_i) begin
            state_reg      <= RUN;
            state_code_reg <= ENC_RUN;
          end else if (rd_empty && wr_empty && w_owed_empty && !ar_hold_reg && !aw_hold_reg) begin
            state_reg      <= SR_ENTER;
            state_code_reg <= ENC_SR;
            app_sr_req_reg <= 1'b1;
          end
        end
        SR_ENTER: begin
          if (sra_sync) begin
            state_reg <= SR_HOLD;
          end
        end
        SR_HOLD: begin
          if (!sr_req_i) begin
            state_reg      <= SR_EXIT;
            app_sr_req_reg <= 1'b0;
          end
        end
        SR_EXIT: begin
          if (!sra_sync) begin
            state_reg      <= RUN;
            state_code_reg <= ENC_RUN;
          end
        end
        default: begin
          state_reg      <= WAIT_CALIB;
          state_code_reg <= ENC_WAIT_CALIB;
          app_sr_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign state_o         = state_code_reg;
  assign app_sr_req_o    = app_sr_req_reg;
  assign calib_timeout_o = calib_timeout_reg;

endmodule
